// File: rtl/rename_free_list_ctrl_if.sv
// Rename-stage handshake with the free list:
// tag allocation, commit release and branch checkpoint control.
interface rename_free_list_ctrl_if #(
    parameter int TAG_W = 6
);
    logic             alloc_req;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             release_valid;
    logic [TAG_W-1:0] release_tag;
    logic             ckpt_save;
    logic             ckpt_restore;

    modport master (
        output alloc_req,
        output release_valid,
        output release_tag,
        output ckpt_save,
        output ckpt_restore,
        input  alloc_ready,
        input  alloc_tag
    );

    modport slave (
        input  alloc_req,
        input  release_valid,
        input  release_tag,
        input  ckpt_save,
        input  ckpt_restore,
        output alloc_ready,
        output alloc_tag
    );
endinterface

// File: rtl/rename_free_list_ctrl.sv
// Free physical tag FIFO for rename: self-fills after reset,
// allocates at head, recycles commits at tail, one head checkpoint.
module rename_free_list_ctrl #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = 6,
    localparam int DEPTH   = NUM_PHYS - NUM_ARCH,
    localparam int PTR_W   = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rename_free_list_ctrl_if.slave fl,
    output logic [PTR_W-1:0]       free_count,
    output logic                   init_busy,
    output logic                   overflow_err
);
    localparam int IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] head, head_nxt;
    logic [PTR_W-1:0] tail, tail_nxt;
    logic [PTR_W-1:0] init_cnt, init_cnt_nxt;
    logic [PTR_W-1:0] ckpt_head, ckpt_nxt;
    logic             err_nxt;

    logic [TAG_W-1:0] mem [DEPTH];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_data;

    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] head_adv;
    logic             running;
    logic             ready;
    logic             fire;
    logic             rel_live;
    logic             full;

    assign count    = tail - head;
    assign full     = (count == FULL);
    assign running  = rst_n && (state == RUN);
    // A restore cycle never issues a tag: the head is about to move back.
    assign ready    = running && (count != '0) && !fl.ckpt_restore;
    assign fire     = fl.alloc_req && ready;
    assign head_adv = fire ? head + ONE : head;
    assign rel_live = fl.release_valid && (fl.release_tag != '0);

    assign fl.alloc_ready = ready;
    assign fl.alloc_tag   = running ? mem[head[IDX_W-1:0]] : '0;
    assign free_count     = rst_n ? count : '0;
    assign init_busy      = !rst_n || (state == INIT);

    always_comb begin
        state_nxt    = state;
        head_nxt     = head;
        tail_nxt     = tail;
        init_cnt_nxt = init_cnt;
        ckpt_nxt     = ckpt_head;
        err_nxt      = overflow_err;
        wr_en        = 1'b0;
        wr_idx       = tail[IDX_W-1:0];
        wr_data      = fl.release_tag;
        unique case (state)
            INIT: begin
                wr_en        = 1'b1;
                wr_data      = TAG_W'(NUM_ARCH) + TAG_W'(init_cnt);
                tail_nxt     = tail + ONE;
                init_cnt_nxt = init_cnt + ONE;
                if (fl.release_valid)
                    err_nxt = 1'b1;
                if (init_cnt == LAST)
                    state_nxt = RUN;
            end
            RUN: begin
                head_nxt = fl.ckpt_restore ? ckpt_head : head_adv;
                // Snapshot includes this cycle's allocation.
                if (fl.ckpt_save && !fl.ckpt_restore)
                    ckpt_nxt = head_adv;
                if (rel_live && full)
                    err_nxt = 1'b1;
                if (rel_live && !full) begin
                    wr_en    = 1'b1;
                    tail_nxt = tail + ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= INIT;
            head         <= '0;
            tail         <= '0;
            init_cnt     <= '0;
            ckpt_head    <= '0;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            head         <= head_nxt;
            tail         <= tail_nxt;
            init_cnt     <= init_cnt_nxt;
            ckpt_head    <= ckpt_nxt;
            overflow_err <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem[wr_idx] <= wr_data;
    end
endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Bench for rename_free_list_ctrl: queue-based reference model
// checked every cycle plus directed literal expectations.
module tb_rename_free_list_ctrl;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] free_count;
    logic       init_busy;
    logic       overflow_err;

    rename_free_list_ctrl_if #(.TAG_W(6)) fl ();

    rename_free_list_ctrl #(
        .NUM_PHYS(64),
        .NUM_ARCH(32),
        .TAG_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fl(fl),
        .free_count(free_count),
        .init_busy(init_busy),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    bit go = 1'b0;

    // Reference: free tags as a queue; tags issued since the checkpoint.
    int fq[$];
    int since[$];
    bit m_run = 1'b0;
    int m_init = 0;
    bit m_err = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            bit rdy;
            bit fire;
            bit full;
            if (!rst_n) begin
                chk("rst_ready", int'(fl.alloc_ready), 0);
                chk("rst_tag", int'(fl.alloc_tag), 0);
                chk("rst_busy", int'(init_busy), 1);
                chk("rst_count", int'(free_count), 0);
                chk("rst_err", int'(overflow_err), int'(m_err));
                fq.delete();
                since.delete();
                m_run = 1'b0;
                m_init = 0;
                m_err = 1'b0;
            end else begin
                rdy = m_run && (fq.size() != 0) && !fl.ckpt_restore;
                chk("ready", int'(fl.alloc_ready), int'(rdy));
                chk("count", int'(free_count), fq.size());
                chk("busy", int'(init_busy), int'(!m_run));
                chk("err", int'(overflow_err), int'(m_err));
                if (rdy)
                    chk("tag", int'(fl.alloc_tag), fq[0]);
                if (!m_run) begin
                    fq.push_back(32 + m_init);
                    m_init++;
                    if (m_init == DEPTH) m_run = 1'b1;
                    if (fl.release_valid) m_err = 1'b1;
                end else begin
                    full = (fq.size() == DEPTH);
                    fire = fl.alloc_req && rdy;
                    if (fire) since.push_back(fq.pop_front());
                    if (fl.ckpt_save && !fl.ckpt_restore) since.delete();
                    if (fl.release_valid && fl.release_tag != 0) begin
                        if (full) m_err = 1'b1;
                        else fq.push_back(int'(fl.release_tag));
                    end
                    if (fl.ckpt_restore) begin
                        for (int i = since.size() - 1; i >= 0; i--)
                            fq.push_front(since[i]);
                        since.delete();
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        fl.alloc_req = 1'b0;
        fl.release_valid = 1'b0;
        fl.release_tag = '0;
        fl.ckpt_save = 1'b0;
        fl.ckpt_restore = 1'b0;
        @(posedge clk);
        go = 1'b1;
        #1;
        step();

        // 1: fill after reset
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("t1_busy_last", int'(init_busy), 1);
            step();
        end
        chk("t1_busy", int'(init_busy), 0);
        chk("t1_count", int'(free_count), 32);
        chk("t1_ready", int'(fl.alloc_ready), 1);
        chk("t1_tag", int'(fl.alloc_tag), 32);

        // 2: drain in order
        fl.alloc_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("t2_tag", int'(fl.alloc_tag), 32 + i);
            step();
        end
        fl.alloc_req = 1'b0;
        #1;
        chk("t2_count", int'(free_count), 0);
        chk("t2_ready", int'(fl.alloc_ready), 0);

        // 3: zero tag ignored, then release 5 with one-cycle latency
        fl.release_valid = 1'b1;
        fl.release_tag = 6'd0;
        step();
        fl.release_tag = 6'd5;
        #1;
        chk("t3_nobypass", int'(fl.alloc_ready), 0);
        step();
        fl.release_valid = 1'b0;
        #1;
        chk("t3_ready", int'(fl.alloc_ready), 1);
        chk("t3_tag", int'(fl.alloc_tag), 5);
        chk("t3_count", int'(free_count), 1);
        chk("t3_err", int'(overflow_err), 0);

        // 4: simultaneous alloc and release at count 10
        fl.release_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            fl.release_tag = 6'(10 + i);
            step();
        end
        fl.release_valid = 1'b0;
        #1;
        chk("t4_count_pre", int'(free_count), 10);
        fl.alloc_req = 1'b1;
        fl.release_valid = 1'b1;
        fl.release_tag = 6'd7;
        step();
        fl.alloc_req = 1'b0;
        fl.release_valid = 1'b0;
        #1;
        chk("t4_count_post", int'(free_count), 10);
        fl.alloc_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 9) chk("t4_tail_tag", int'(fl.alloc_tag), 7);
            step();
        end
        fl.alloc_req = 1'b0;
        #1;
        chk("t4_empty", int'(free_count), 0);

        // 5: checkpoint save / restore
        fl.release_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fl.release_tag = 6'(20 + i);
            step();
        end
        fl.release_valid = 1'b0;
        fl.ckpt_save = 1'b1;
        step();
        fl.ckpt_save = 1'b0;
        fl.alloc_req = 1'b1;
        step();
        step();
        step();
        fl.ckpt_restore = 1'b1;
        #1;
        chk("t5_restore_noready", int'(fl.alloc_ready), 0);
        step();
        fl.ckpt_restore = 1'b0;
        fl.alloc_req = 1'b0;
        #1;
        chk("t5_count", int'(free_count), 10);
        chk("t5_tag", int'(fl.alloc_tag), 20);

        fl.ckpt_save = 1'b1;
        fl.alloc_req = 1'b1;
        step();
        fl.ckpt_save = 1'b0;
        step();
        step();
        fl.alloc_req = 1'b0;
        fl.ckpt_restore = 1'b1;
        step();
        fl.ckpt_restore = 1'b0;
        #1;
        chk("t5_save_alloc_tag", int'(fl.alloc_tag), 21);
        chk("t5_save_alloc_cnt", int'(free_count), 9);

        fl.alloc_req = 1'b1;
        step();
        step();
        fl.alloc_req = 1'b0;
        fl.ckpt_save = 1'b1;
        fl.ckpt_restore = 1'b1;
        step();
        fl.ckpt_save = 1'b0;
        fl.ckpt_restore = 1'b0;
        #1;
        chk("t5_both_tag", int'(fl.alloc_tag), 21);
        fl.alloc_req = 1'b1;
        step();
        step();
        fl.alloc_req = 1'b0;
        fl.ckpt_restore = 1'b1;
        step();
        fl.ckpt_restore = 1'b0;
        #1;
        chk("t5_kept_tag", int'(fl.alloc_tag), 21);
        chk("t5_kept_cnt", int'(free_count), 9);

        // 6: full drop, zero ignore, mid-run reset
        fl.release_valid = 1'b1;
        for (int i = 0; i < 23; i++) begin
            fl.release_tag = 6'(i + 1);
            step();
        end
        fl.release_tag = 6'd0;
        step();
        fl.release_valid = 1'b0;
        #1;
        chk("t6_full", int'(free_count), 32);
        chk("t6_zero_noerr", int'(overflow_err), 0);
        fl.release_valid = 1'b1;
        fl.release_tag = 6'd40;
        step();
        fl.release_valid = 1'b0;
        #1;
        chk("t6_err", int'(overflow_err), 1);
        chk("t6_dropped", int'(free_count), 32);
        fl.alloc_req = 1'b1;
        step();
        fl.alloc_req = 1'b0;
        step();
        step();
        chk("t6_sticky", int'(overflow_err), 1);

        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", int'(free_count), 0);
        chk("t6_rst_busy", int'(init_busy), 1);
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_rst_err", int'(overflow_err), 0);
        for (int i = 0; i < 32; i++) begin
            fl.release_valid = (i == 3);
            fl.release_tag = 6'd9;
            step();
        end
        fl.release_valid = 1'b0;
        #1;
        chk("t6_refill_tag", int'(fl.alloc_tag), 32);
        chk("t6_refill_cnt", int'(free_count), 32);
        chk("t6_init_rel_err", int'(overflow_err), 1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
